// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: ball/paddle geometry in, animator control and game status out
interface pong_game_ctrl_if;
  logic        i_ani_stb;
  logic        i_start;
  logic [11:0] i_ball_x1;
  logic [11:0] i_ball_x2;
  logic [11:0] i_ball_y1;
  logic [11:0] i_ball_y2;
  logic [11:0] i_pad_x1;
  logic [11:0] i_pad_x2;
  logic        o_animate;
  logic        o_ball_rst;
  logic        o_bounce;
  logic [15:0] o_score;
  logic [2:0]  o_lives;
  logic [2:0]  o_state;
  logic        o_game_over;
  modport master (
    output i_ani_stb, i_start, i_ball_x1, i_ball_x2, i_ball_y1, i_ball_y2, i_pad_x1, i_pad_x2,
    input  o_animate, o_ball_rst, o_bounce, o_score, o_lives, o_state, o_game_over
  );
  modport slave (
    input  i_ani_stb, i_start, i_ball_x1, i_ball_x2, i_ball_y1, i_ball_y2, i_pad_x1, i_pad_x2,
    output o_animate, o_ball_rst, o_bounce, o_score, o_lives, o_state, o_game_over
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: serve/play/miss game FSM with paddle-hit detection, BCD score and lives
module pong_game_ctrl #(
  parameter int D_HEIGHT     = 480,
  parameter int PADDLE_Y     = 460,
  parameter int HIT_TOL      = 4,
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60
) (
  input logic              i_clk,
  input logic              i_rst,
  pong_game_ctrl_if.slave  bus
);
  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [11:0] PY = 12'(PADDLE_Y);
  localparam logic [11:0] PT = 12'(PADDLE_Y + HIT_TOL);
  localparam logic [11:0] MY = 12'(D_HEIGHT - 1);
  localparam logic [2:0] LV = 3'(LIVES);
  localparam logic [CW-1:0] SL = CW'(SERVE_FRAMES - 1);
  typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, MISS = 3'd3, OVER = 3'd4} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic hit_lock, lock_n, start_q, bounce, bounce_n, animate, ball_rst, game_over;
  logic [15:0] score, score_n;
  logic [2:0] lives, lives_n;
  logic start_edge, overlap, hit, unused;
  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic c;
    r = s;
    c = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (c) begin
        c = (s[4*k +: 4] == 4'd9);
        r[4*k +: 4] = c ? 4'd0 : s[4*k +: 4] + 4'd1;
      end
    end
    return (s == 16'h9999) ? s : r;
  endfunction
  assign unused = ^bus.i_ball_y1;
  assign start_edge = bus.i_start & ~start_q;
  assign overlap = (bus.i_ball_x2 >= bus.i_pad_x1) && (bus.i_ball_x1 <= bus.i_pad_x2);
  assign hit = !hit_lock && overlap && bus.i_ball_y2 >= PY && bus.i_ball_y2 <= PT;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    lock_n = hit_lock;
    score_n = score;
    lives_n = lives;
    bounce_n = 1'b0;
    case (state)
      IDLE, OVER: if (start_edge) begin
        state_n = SERVE;
        score_n = '0;
        lives_n = LV;
        cnt_n = '0;
      end
      SERVE: if (bus.i_ani_stb) begin
        cnt_n = (cnt == SL) ? '0 : cnt + 1'b1;
        state_n = (cnt == SL) ? PLAY : SERVE;
        lock_n = (cnt == SL) ? 1'b0 : hit_lock;
      end
      PLAY: if (bus.i_ani_stb) begin
        bounce_n = hit;
        score_n = hit ? bcd_inc(score) : score;
        lock_n = hit ? 1'b1 : (bus.i_ball_y2 < PY) ? 1'b0 : hit_lock;
        state_n = (bus.i_ball_y2 >= MY) ? MISS : PLAY;
        lives_n = (bus.i_ball_y2 >= MY) ? lives - 3'd1 : lives;
      end
      MISS: begin
        state_n = (lives == 3'd0) ? OVER : SERVE;
        cnt_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  // control outputs follow the state being entered so they line up with o_state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      hit_lock <= 1'b0;
      start_q <= 1'b0;
      score <= '0;
      lives <= LV;
      bounce <= 1'b0;
      animate <= 1'b0;
      ball_rst <= 1'b1;
      game_over <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      hit_lock <= lock_n;
      start_q <= bus.i_start;
      score <= score_n;
      lives <= lives_n;
      bounce <= bounce_n;
      animate <= (state_n == PLAY);
      ball_rst <= (state_n != PLAY);
      game_over <= (state_n == OVER);
    end
  end
  assign bus.o_animate = animate;
  assign bus.o_ball_rst = ball_rst;
  assign bus.o_bounce = bounce;
  assign bus.o_score = score;
  assign bus.o_lives = lives;
  assign bus.o_state = state;
  assign bus.o_game_over = game_over;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed-step bench for serve, hit/lock, miss, game over, BCD and reset
module tb_pong_game_ctrl;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int total = 0;
  int bad = 0;
  pong_game_ctrl_if bus();
  pong_game_ctrl dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic strobe(input logic [11:0] y2);
    bus.i_ball_y2 = y2;
    bus.i_ani_stb = 1'b1;
    tick();
    bus.i_ani_stb = 1'b0;
  endtask
  task automatic serve();
    repeat (60) strobe(12'd0);
  endtask
  task automatic hits(input int n);
    repeat (n) begin
      strobe(12'd460);
      strobe(12'd400);
    end
  endtask
  task automatic play_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    serve();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bus.i_ani_stb = 1'b0;
    bus.i_start = 1'b0;
    bus.i_ball_x1 = 12'd300;
    bus.i_ball_x2 = 12'd340;
    bus.i_ball_y1 = 12'd0;
    bus.i_ball_y2 = 12'd0;
    bus.i_pad_x1 = 12'd280;
    bus.i_pad_x2 = 12'd360;
    tick();
    tick();
    chk("rst_state", bus.o_state, 0);
    chk("rst_ball_rst", bus.o_ball_rst, 1);
    chk("rst_animate", bus.o_animate, 0);
    chk("rst_bounce", bus.o_bounce, 0);
    chk("rst_score", bus.o_score, 16'h0000);
    chk("rst_lives", bus.o_lives, 3);
    chk("rst_over", bus.o_game_over, 0);
    i_rst = 1'b0;
    tick();
    chk("idle_hold", bus.o_state, 0);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("serve_state", bus.o_state, 1);
    chk("serve_ball_rst", bus.o_ball_rst, 1);
    repeat (59) strobe(12'd0);
    chk("serve_59", bus.o_state, 1);
    chk("serve_59_anim", bus.o_animate, 0);
    strobe(12'd0);
    chk("play_state", bus.o_state, 2);
    chk("play_animate", bus.o_animate, 1);
    chk("play_ball_rst", bus.o_ball_rst, 0);
    strobe(12'd462);
    chk("hit1_bounce", bus.o_bounce, 1);
    chk("hit1_score", bus.o_score, 16'h0001);
    tick();
    chk("hit1_pulse_end", bus.o_bounce, 0);
    strobe(12'd463);
    chk("lock_bounce", bus.o_bounce, 0);
    chk("lock_score", bus.o_score, 16'h0001);
    strobe(12'd400);
    chk("clear_bounce", bus.o_bounce, 0);
    strobe(12'd460);
    chk("hit2_bounce", bus.o_bounce, 1);
    chk("hit2_score", bus.o_score, 16'h0002);
    strobe(12'd400);
    bus.i_ball_x1 = 12'd200;
    bus.i_ball_x2 = 12'd280;
    strobe(12'd460);
    chk("edge_bounce", bus.o_bounce, 1);
    chk("edge_score", bus.o_score, 16'h0003);
    strobe(12'd400);
    bus.i_ball_x1 = 12'd199;
    bus.i_ball_x2 = 12'd279;
    strobe(12'd460);
    chk("near_bounce", bus.o_bounce, 0);
    chk("near_score", bus.o_score, 16'h0003);
    strobe(12'd479);
    chk("miss_state", bus.o_state, 3);
    chk("miss_lives", bus.o_lives, 2);
    chk("miss_animate", bus.o_animate, 0);
    chk("miss_ball_rst", bus.o_ball_rst, 1);
    tick();
    chk("miss_to_serve", bus.o_state, 1);
    serve();
    strobe(12'd479);
    tick();
    chk("miss2_lives", bus.o_lives, 1);
    serve();
    strobe(12'd479);
    chk("miss3_lives", bus.o_lives, 0);
    tick();
    chk("over_state", bus.o_state, 4);
    chk("over_flag", bus.o_game_over, 1);
    chk("over_score", bus.o_score, 16'h0003);
    strobe(12'd460);
    chk("over_hold", bus.o_state, 4);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("restart_state", bus.o_state, 1);
    chk("restart_lives", bus.o_lives, 3);
    chk("restart_score", bus.o_score, 16'h0000);
    chk("restart_over", bus.o_game_over, 0);
    bus.i_ball_x1 = 12'd300;
    bus.i_ball_x2 = 12'd340;
    serve();
    hits(99);
    chk("bcd_99", bus.o_score, 16'h0099);
    strobe(12'd460);
    chk("bcd_100", bus.o_score, 16'h0100);
    strobe(12'd400);
    hits(9899);
    chk("bcd_9999", bus.o_score, 16'h9999);
    strobe(12'd460);
    chk("sat_bounce", bus.o_bounce, 1);
    chk("sat_score", bus.o_score, 16'h9999);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    play_start();
    hits(42);
    chk("pre_rst_score", bus.o_score, 16'h0042);
    chk("pre_rst_state", bus.o_state, 2);
    i_rst = 1'b1;
    bus.i_start = 1'b1;
    tick();
    chk("midrst_state", bus.o_state, 0);
    chk("midrst_score", bus.o_score, 16'h0000);
    chk("midrst_lives", bus.o_lives, 3);
    chk("midrst_animate", bus.o_animate, 0);
    chk("midrst_ball_rst", bus.o_ball_rst, 1);
    i_rst = 1'b0;
    tick();
    chk("held_start_serve", bus.o_state, 1);
    tick();
    chk("held_start_once", bus.o_state, 1);
    bus.i_start = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
